calc1_port_driver: RTL
======================

# calc1_port_driver

Request-side adapter placed directly upstream of one `calc1` request port. It accepts complete transactions (command plus two operands) on a valid/ready interface and serialises each onto the two-cycle `calc1` port protocol: command with operand 1, then command 0 with operand 2. It waits for the port response, enforces a timeout, and returns result and response code on a valid/ready response interface. Four instances, one per `calc1` port, form the stimulus front end of the calculator environment.

## Interface
- `TIMEOUT_CYCLES`, 64: WAIT cycles without a port response before local timeout; legal 1..1023.
- `c_clk`  in  1  clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  transaction offered.
- `req_ready`  out  1  driver can accept; high only in IDLE.
- `req_cmd`  in  [0:3]  calc1 command code.
- `req_op1`  in  [0:31]  first operand.
- `req_op2`  in  [0:31]  second operand.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_code`  out  [0:1]  1 success, 2 calc1 error or local cmd-0 reject, 3 timeout.
- `rsp_data`  out  [0:31]  result data.
- `port_cmd_out`  out  [0:3]  to `calc1` reqN_cmd_in.
- `port_data_out`  out  [0:31]  to `calc1` reqN_data_in.
- `port_resp_in`  in  [0:1]  from `calc1` out_respN.
- `port_data_in`  in  [0:31]  from `calc1` out_dataN.
- `busy`  out  1  state other than IDLE.
- `err_late`  out  1  sticky: nonzero port response seen outside WAIT.

## Operation
- States: IDLE, OP1, OP2, WAIT, HOLD.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`, register cmd/op1/op2. Nonzero cmd goes to OP1. Cmd 0 goes straight to HOLD with code 2, data 0, and produces no port activity.
- OP1: `port_cmd_out`=cmd, `port_data_out`=op1; next state OP2.
- OP2: `port_cmd_out`=0, `port_data_out`=op2; next state WAIT, with the timer cleared.
- WAIT: port outputs 0. Timer increments each cycle.
  - `port_resp_in`≠0: capture `port_resp_in` as code and `port_data_in` as data, then go to HOLD.
  - Timer reaches `TIMEOUT_CYCLES` with no response: code 3, data 0, go to HOLD.
  - Response in the same cycle as expiry: the response wins.
- HOLD: `rsp_valid`=1; `rsp_code`/`rsp_data` stay stable until `rsp_ready`. On handshake, go to IDLE.
- Commands 1..15 other than 0 are forwarded unmodified. Validity checking belongs to `calc1`; the driver does not decode them.
- Nonzero `port_resp_in` in IDLE, OP1, OP2 or HOLD sets `err_late` and is not captured. `err_late` clears only on reset.
- Data widths are fixed at 32 bits. No arithmetic is performed on operands.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, timer 0. Outputs `rsp_valid`, `rsp_code`, `rsp_data`, `port_cmd_out`, `port_data_out`, `busy` and `err_late` go to 0. `req_ready` is 1 once reset releases.
- Reset mid-transaction abandons it. A `calc1` response arriving afterwards sets `err_late`.
- Accept at edge k. OP1 drives during cycle k+1, OP2 during cycle k+2, WAIT begins at k+3.
- Response sampled at edge m gives `rsp_valid` from cycle m+1.
- Cmd 0 accepted at edge k gives `rsp_valid` in cycle k+1.
- Timeout: `rsp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after WAIT entry.
- After the response handshake at edge h, `req_ready`=1 in cycle h+1. There is no same-cycle turnaround.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `calc1_pkg`:
  - command constants: NOP 0, ADD 1, SUB 2, SHL 5, SHR 6;
  - response constants: NONE 0, OK 1, ERR 2, TMO 3;
  - driver state enum;
  - data width 32 and command width 4.
- One sub-module, `calc1_wait_timer`: 10-bit clear/enable counter with an expiry compare against `TIMEOUT_CYCLES`.

## Test plan
- ADD 0000_0001 + 1FFF_FFFF.
  - Port shows cmd 1/0000_0001, then 0/1FFF_FFFF.
  - Model returns resp 1, data 2000_0000 three cycles later.
  - Expect `rsp_code`=1, `rsp_data`=2000_0000.
- ADD FFFF_FFFF + 0000_0001.
  - Model returns resp 2, data 0.
  - Expect `rsp_code`=2, `rsp_data`=0, and the port sequence matches the two-cycle protocol.
- `req_cmd`=0.
  - Expect no port activity and `rsp_valid` one cycle after acceptance with code 2, data 0.
- `TIMEOUT_CYCLES`=8, model silent.
  - Expect `rsp_code`=3 exactly 9 cycles after WAIT entry.
  - A model resp 1 injected afterwards sets `err_late`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while a second `req_valid` is pending.
  - Response stays stable and `req_ready`=0.
  - The second request is accepted in the cycle after the handshake.
- Assert `reset` during OP2.
  - All outputs are 0 immediately and `req_ready`=1 after release.
  - A later port response sets `err_late`.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 request-side environment: command and
// response codes, field widths and the port driver state encoding.
package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_ERR  = 2'd2;
  localparam logic [1:0] RSP_TMO  = 2'd3;

  typedef enum logic [2:0] {
    DRV_IDLE,
    DRV_OP1,
    DRV_OP2,
    DRV_WAIT,
    DRV_HOLD
  } drv_state_e;

endpackage

// File: rtl/calc1_wait_timer.sv
// Response wait timer for the calc1 port driver. Counts cycles spent waiting
// for a port response and flags when the configured limit has been reached.
module calc1_wait_timer
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [9:0] LIMIT = 10'(TIMEOUT_CYCLES);

  logic [9:0] count;

  // Clear takes priority so a new wait window always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 10'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/calc1_port_driver.sv
// Request-side adapter for one calc1 port. Takes a whole transaction on a
// valid/ready interface, plays it onto the two-cycle calc1 port protocol,
// waits (with timeout) for the port response and hands it back on a
// valid/ready response interface. Every output comes straight from a flop.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CMD_W-1:0]  port_cmd_out,
  output logic [DATA_W-1:0] port_data_out,
  input  logic [1:0]        port_resp_in,
  input  logic [DATA_W-1:0] port_data_in,
  output logic              busy,
  output logic              err_late
);

  drv_state_e        state_q;
  drv_state_e        state_d;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] op2_d;
  logic [CMD_W-1:0]  port_cmd_d;
  logic [DATA_W-1:0] port_data_d;
  logic              rsp_valid_d;
  logic [1:0]        rsp_code_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              req_ready_d;
  logic              busy_d;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;
  logic              late_resp;

  calc1_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (c_clk),
    .rst_n  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // Any response appearing while no transaction is waiting for one is
  // recorded as a protocol anomaly and otherwise ignored.
  assign late_resp = (state_q != DRV_WAIT) && (port_resp_in != RSP_NONE);

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d      = state_q;
    op2_d        = op2_q;
    port_cmd_d   = CMD_NOP;
    port_data_d  = '0;
    rsp_valid_d  = 1'b0;
    rsp_code_d   = rsp_code;
    rsp_data_d   = rsp_data;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      DRV_IDLE: begin
        if (req_valid && req_ready) begin
          op2_d = req_op2;
          if (req_cmd != CMD_NOP) begin
            state_d     = DRV_OP1;
            port_cmd_d  = req_cmd;
            port_data_d = req_op1;
          end else begin
            state_d     = DRV_HOLD;
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_ERR;
            rsp_data_d  = '0;
          end
        end
      end

      DRV_OP1: begin
        state_d     = DRV_OP2;
        port_cmd_d  = CMD_NOP;
        port_data_d = op2_q;
      end

      DRV_OP2: begin
        state_d     = DRV_WAIT;
        timer_clear = 1'b1;
      end

      DRV_WAIT: begin
        timer_enable = 1'b1;
        if (port_resp_in != RSP_NONE) begin
          state_d     = DRV_HOLD;
          rsp_valid_d = 1'b1;
          rsp_code_d  = port_resp_in;
          rsp_data_d  = port_data_in;
        end else if (timer_expired) begin
          state_d     = DRV_HOLD;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_TMO;
          rsp_data_d  = '0;
        end
      end

      DRV_HOLD: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = DRV_IDLE;
          rsp_valid_d = 1'b0;
          rsp_code_d  = RSP_NONE;
          rsp_data_d  = '0;
        end
      end

      default: begin
        state_d = DRV_IDLE;
      end
    endcase

    req_ready_d = (state_d == DRV_IDLE);
    busy_d      = (state_d != DRV_IDLE);
  end

  // State, captured operand and all outputs update together on the clock.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= DRV_IDLE;
      op2_q         <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_code      <= RSP_NONE;
      rsp_data      <= '0;
      port_cmd_out  <= CMD_NOP;
      port_data_out <= '0;
      busy          <= 1'b0;
      err_late      <= 1'b0;
    end else begin
      state_q       <= state_d;
      op2_q         <= op2_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_code      <= rsp_code_d;
      rsp_data      <= rsp_data_d;
      port_cmd_out  <= port_cmd_d;
      port_data_out <= port_data_d;
      busy          <= busy_d;
      err_late      <= err_late | late_resp;
    end
  end

endmodule
